// File: rtl/lm75_i2c_target.sv
// LM75-compatible I2C target: pointer, Temp, Config, Thyst and Tos registers behind an
// oversampled Scl/Sda front end. It never stretches Scl and only moves Sda while Scl is low.
module lm75_i2c_target #(
    parameter logic [6:0] SLAVE_ADR = 7'h48
) (
    input  logic        Clk_in,
    input  logic        Rst,
    input  logic        Scl_in,
    input  logic        Sda_in,
    input  logic [15:0] Temp,
    output logic        Sda_oe,
    output logic        Os,
    output logic        Busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic [1:0] sclSync_q;
    logic [1:0] sdaSync_q;
    logic       sclHist_q;
    logic       sdaHist_q;

    state_t      state_q, state_d;
    logic [3:0]  bitCnt_q, bitCnt_d;
    logic [1:0]  byteCnt_q, byteCnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic        rdLsb_q, rdLsb_d;
    logic        mAck_q, mAck_d;
    logic        sdaOe_q, sdaOe_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  config_q, config_d;
    logic [15:0] thyst_q, thyst_d;
    logic [15:0] tos_q, tos_d;
    logic [7:0]  wrMsb_q, wrMsb_d;
    logic [15:0] tempSnap_q, tempSnap_d;
    logic        osState_q, osState_d;

    logic sclNow, sdaNow;
    logic sclRise, sclFall;
    logic startCond, stopCond;
    logic wrByteOk;
    logic tGeTos, tLtHyst;
    logic [7:0] firstByte, nextByte;

    // Synchronizers idle high so releasing reset on an idle bus produces no edges.
    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            sclSync_q <= 2'b11;
            sdaSync_q <= 2'b11;
            sclHist_q <= 1'b1;
            sdaHist_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[0], Scl_in};
            sdaSync_q <= {sdaSync_q[0], Sda_in};
            sclHist_q <= sclSync_q[1];
            sdaHist_q <= sdaSync_q[1];
        end
    end

    assign sclNow    = sclSync_q[1];
    assign sdaNow    = sdaSync_q[1];
    assign sclRise   = sclNow & ~sclHist_q;
    assign sclFall   = ~sclNow & sclHist_q;
    assign startCond = sclNow & sclHist_q & sdaHist_q & ~sdaNow;
    assign stopCond  = sclNow & sclHist_q & ~sdaHist_q & sdaNow;

    // Temp bits 6:0 carry no information and read back as zero.
    function automatic logic [7:0] selByte(
        input logic [1:0]  p,
        input logic        lsb,
        input logic [15:0] t,
        input logic [7:0]  c,
        input logic [15:0] th,
        input logic [15:0] to
    );
        logic [7:0] b;
        case (p)
            2'd0:    b = lsb ? {t[7], 7'b0} : t[15:8];
            2'd1:    b = c;
            2'd2:    b = lsb ? th[7:0] : th[15:8];
            default: b = lsb ? to[7:0] : to[15:8];
        endcase
        return b;
    endfunction

    assign firstByte = selByte(ptr_q, 1'b0, Temp, config_q, thyst_q, tos_q);
    assign nextByte  = selByte(ptr_q, ~rdLsb_q, tempSnap_q, config_q, thyst_q, tos_q);

    // Config accepts one data byte, Thyst/Tos accept two; Temp accepts none.
    assign wrByteOk = ((ptr_q == 2'd1) && (byteCnt_q == 2'd1)) ||
                      (ptr_q[1] && ((byteCnt_q == 2'd1) || (byteCnt_q == 2'd2)));

    assign tGeTos  = $signed(Temp[15:7]) >= $signed(tos_q[15:7]);
    assign tLtHyst = $signed(Temp[15:7]) <  $signed(thyst_q[15:7]);

    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            byteCnt_q  <= 2'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            rdLsb_q    <= 1'b0;
            mAck_q     <= 1'b0;
            sdaOe_q    <= 1'b0;
            ptr_q      <= 2'd0;
            config_q   <= 8'h00;
            thyst_q    <= 16'h4B00;
            tos_q      <= 16'h5000;
            wrMsb_q    <= 8'h00;
            tempSnap_q <= 16'h0000;
            osState_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            byteCnt_q  <= byteCnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            rdLsb_q    <= rdLsb_d;
            mAck_q     <= mAck_d;
            sdaOe_q    <= sdaOe_d;
            ptr_q      <= ptr_d;
            config_q   <= config_d;
            thyst_q    <= thyst_d;
            tos_q      <= tos_d;
            wrMsb_q    <= wrMsb_d;
            tempSnap_q <= tempSnap_d;
            osState_q  <= osState_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        byteCnt_d  = byteCnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        rdLsb_d    = rdLsb_q;
        mAck_d     = mAck_q;
        sdaOe_d    = sdaOe_q;
        ptr_d      = ptr_q;
        config_d   = config_q;
        thyst_d    = thyst_q;
        tos_d      = tos_q;
        wrMsb_d    = wrMsb_q;
        tempSnap_d = tempSnap_q;
        osState_d  = osState_q;

        // Comparator with hysteresis; shutdown freezes the flag.
        if (!config_q[0]) begin
            if (tGeTos) begin
                osState_d = 1'b1;
            end else if (tLtHyst) begin
                osState_d = 1'b0;
            end
        end

        if (stopCond) begin
            state_d = IDLE;
            sdaOe_d = 1'b0;
        end else if (startCond) begin
            state_d  = ADDR;
            bitCnt_d = 4'd0;
            sdaOe_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (sclRise && (bitCnt_q != 4'd8)) begin
                        shift_d  = {shift_q[6:0], sdaNow};
                        bitCnt_d = bitCnt_q + 4'd1;
                    end else if (sclFall && (bitCnt_q == 4'd8)) begin
                        bitCnt_d = 4'd0;
                        if (shift_q[7:1] == SLAVE_ADR) begin
                            state_d = ADDR_ACK;
                            sdaOe_d = 1'b1;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end

                // The fall ending the ACK either starts a write or presents the first read bit.
                ADDR_ACK: begin
                    if (sclFall) begin
                        byteCnt_d = 2'd0;
                        bitCnt_d  = 4'd0;
                        if (rw_q) begin
                            state_d    = RD_BYTE;
                            tempSnap_d = Temp;
                            shift_d    = firstByte;
                            sdaOe_d    = ~firstByte[7];
                            rdLsb_d    = 1'b0;
                        end else begin
                            state_d = WR_BYTE;
                            sdaOe_d = 1'b0;
                        end
                    end
                end

                WR_BYTE: begin
                    if (sclRise && (bitCnt_q != 4'd8)) begin
                        shift_d  = {shift_q[6:0], sdaNow};
                        bitCnt_d = bitCnt_q + 4'd1;
                    end else if (sclFall && (bitCnt_q == 4'd8)) begin
                        bitCnt_d = 4'd0;
                        if ((byteCnt_q == 2'd0) || wrByteOk) begin
                            state_d = WR_ACK;
                            sdaOe_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end

                // Commits land on the rising edge of the ACK bit; a lone 16-bit MSB never commits.
                WR_ACK: begin
                    if (sclRise) begin
                        case (byteCnt_q)
                            2'd0: ptr_d = shift_q[1:0];
                            2'd1: begin
                                if (ptr_q == 2'd1) begin
                                    config_d = shift_q;
                                end else begin
                                    wrMsb_d = shift_q;
                                end
                            end
                            2'd2: begin
                                if (ptr_q == 2'd2) begin
                                    thyst_d = {wrMsb_q, shift_q};
                                end else begin
                                    tos_d = {wrMsb_q, shift_q};
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (sclFall) begin
                        sdaOe_d   = 1'b0;
                        byteCnt_d = byteCnt_q + 2'd1;
                        state_d   = WR_BYTE;
                    end
                end

                RD_BYTE: begin
                    if (sclFall) begin
                        if (bitCnt_q == 4'd7) begin
                            state_d  = RD_ACK;
                            sdaOe_d  = 1'b0;
                            bitCnt_d = 4'd0;
                        end else begin
                            bitCnt_d = bitCnt_q + 4'd1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            sdaOe_d  = ~shift_q[6];
                        end
                    end
                end

                RD_ACK: begin
                    if (sclRise) begin
                        mAck_d = ~sdaNow;
                    end else if (sclFall) begin
                        if (mAck_q) begin
                            state_d = RD_BYTE;
                            rdLsb_d = ~rdLsb_q;
                            shift_d = nextByte;
                            sdaOe_d = ~nextByte[7];
                        end else begin
                            state_d = WAIT_STOP;
                            sdaOe_d = 1'b0;
                        end
                    end
                end

                WAIT_STOP: begin
                end

                default: begin
                    state_d = IDLE;
                    sdaOe_d = 1'b0;
                end
            endcase
        end
    end

    assign Sda_oe = sdaOe_q;
    assign Os     = osState_q ^ config_q[2];
    assign Busy   = (state_q == ADDR_ACK) || (state_q == WR_BYTE) || (state_q == WR_ACK) ||
                    (state_q == RD_BYTE)  || (state_q == RD_ACK);

endmodule

// File: tb/tb_lm75_i2c_target.sv
// Bench for lm75_i2c_target: bit-banged I2C master on an open-drain bus, checked against a
// transaction-level LM75 register model.
`timescale 1ns/1ps
module tb_lm75_i2c_target;

    localparam int Q = 30;

    logic        clk;
    logic        rstN;
    logic        sclM;
    logic        mLow;
    logic [15:0] temp;
    logic        sdaLine;
    logic        sdaOe;
    logic        os;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    logic [1:0]  mPtr;
    logic [7:0]  mCfg;
    logic [15:0] mThyst;
    logic [15:0] mTos;
    logic        mOsState;
    logic        prevOe = 1'b0;

    lm75_i2c_target #(.SLAVE_ADR(7'h48)) dut (
        .Clk_in (clk),
        .Rst    (rstN),
        .Scl_in (sclM),
        .Sda_in (sdaLine),
        .Temp   (temp),
        .Sda_oe (sdaOe),
        .Os     (os),
        .Busy   (busy)
    );

    assign sdaLine = ~(mLow | sdaOe);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // The target may only move Sda while Scl is low.
    always @(negedge clk) begin
        if (rstN === 1'b1 && sdaOe !== prevOe) begin
            checkOutput("oeChangeSclLow", {31'b0, sclM}, 32'd0);
        end
        prevOe = sdaOe;
    end

    task automatic modelReset();
        mPtr     = 2'd0;
        mCfg     = 8'h00;
        mThyst   = 16'h4B00;
        mTos     = 16'h5000;
        mOsState = 1'b0;
    endtask

    task automatic modelOsStep();
        int t, lo, hi;
        t  = int'($signed(temp[15:7]));
        lo = int'($signed(mThyst[15:7]));
        hi = int'($signed(mTos[15:7]));
        if (!mCfg[0]) begin
            if (t >= hi) mOsState = 1'b1;
            else if (t < lo) mOsState = 1'b0;
        end
    endtask

    function automatic logic modelOs();
        return mOsState ^ mCfg[2];
    endfunction

    function automatic logic [7:0] modelByte(input int k, input logic [15:0] snap);
        logic odd;
        odd = (k % 2) == 1;
        case (mPtr)
            2'd0:    return odd ? {snap[7], 7'b0} : snap[15:8];
            2'd1:    return mCfg;
            2'd2:    return odd ? mThyst[7:0] : mThyst[15:8];
            default: return odd ? mTos[7:0] : mTos[15:8];
        endcase
    endfunction

    task automatic writeBit(input logic b);
        mLow = ~b;
        #Q sclM = 1'b1;
        #(2*Q) sclM = 1'b0;
        #Q;
    endtask

    task automatic readBit(output logic b);
        mLow = 1'b0;
        #Q sclM = 1'b1;
        #Q b = sdaLine;
        #Q sclM = 1'b0;
        #Q;
    endtask

    task automatic busStart();
        mLow = 1'b0;
        #Q sclM = 1'b1;
        #Q mLow = 1'b1;
        #Q sclM = 1'b0;
        #Q;
    endtask

    task automatic busStop();
        mLow = 1'b1;
        #Q sclM = 1'b1;
        #Q mLow = 1'b0;
        #(2*Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic acked);
        logic bit_;
        for (int i = 7; i >= 0; i--) writeBit(b[i]);
        readBit(bit_);
        acked = ~bit_;
    endtask

    task automatic readByte(output logic [7:0] b, input logic masterAck);
        logic bit_;
        for (int i = 7; i >= 0; i--) begin
            readBit(bit_);
            b[i] = bit_;
        end
        writeBit(~masterAck);
    endtask

    task automatic applyStimulus(input logic [15:0] newTemp);
        temp = newTemp;
        repeat (4) @(negedge clk);
        modelOsStep();
        checkOutput("osTemp", {31'b0, os}, {31'b0, modelOs()});
    endtask

    task automatic doWrite(input logic [7:0] ptrByte, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic       a;
        logic       wantAck;
        logic [7:0] d;
        logic [7:0] msb;
        msb = 8'h00;
        busStart();
        writeByte(8'h90, a);
        checkOutput("wrAddrAck", {31'b0, a}, 32'd1);
        checkOutput("busyWr", {31'b0, busy}, 32'd1);
        writeByte(ptrByte, a);
        checkOutput("ptrAck", {31'b0, a}, 32'd1);
        mPtr = ptrByte[1:0];
        for (int k = 1; k <= n; k++) begin
            d = (k == 1) ? d0 : (k == 2) ? d1 : d2;
            wantAck = ((mPtr == 2'd1) && (k == 1)) || ((mPtr >= 2'd2) && (k <= 2));
            writeByte(d, a);
            checkOutput("dataAck", {31'b0, a}, {31'b0, wantAck});
            if (!wantAck) break;
            if (mPtr == 2'd1) mCfg = d;
            else if (k == 1) msb = d;
            else if (mPtr == 2'd2) mThyst = {msb, d};
            else mTos = {msb, d};
        end
        busStop();
        repeat (2) @(negedge clk);
        modelOsStep();
        checkOutput("busyAfterWr", {31'b0, busy}, 32'd0);
        checkOutput("osAfterWr", {31'b0, os}, {31'b0, modelOs()});
    endtask

    task automatic doRead(input int n, input logic swapTemp, input logic [15:0] midTemp);
        logic       a;
        logic [7:0] b;
        logic [15:0] snap;
        busStart();
        writeByte(8'h91, a);
        checkOutput("rdAddrAck", {31'b0, a}, 32'd1);
        snap = temp;
        for (int k = 0; k < n; k++) begin
            readByte(b, k < n - 1);
            checkOutput("rdByte", {24'b0, b}, {24'b0, modelByte(k, snap)});
            if (swapTemp && k == 0) temp = midTemp;
        end
        checkOutput("busyAfterNack", {31'b0, busy}, 32'd0);
        checkOutput("oeAfterNack", {31'b0, sdaOe}, 32'd0);
        busStop();
        repeat (2) @(negedge clk);
        modelOsStep();
        checkOutput("osAfterRd", {31'b0, os}, {31'b0, modelOs()});
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passCount, checkCount + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic       a;
        logic       bit_;
        logic [8:0] t9;
        int         sel;

        sclM = 1'b1;
        mLow = 1'b0;
        temp = 16'h1980;
        rstN = 1'b1;
        modelReset();
        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstSdaOe", {31'b0, sdaOe}, 32'd0);
        checkOutput("rstOs", {31'b0, os}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        modelOsStep();

        $display("[TB] Temp read with pointer 0 and MSB wrap");
        doRead(3, 1'b0, 16'h0000);

        $display("[TB] Tos write and readback");
        doWrite(8'h03, 2, 8'h55, 8'h00, 8'h00);
        doRead(2, 1'b0, 16'h0000);
        doWrite(8'h03, 2, 8'h50, 8'h00, 8'h00);

        $display("[TB] Foreign address");
        busStart();
        writeByte(8'h92, a);
        checkOutput("badAddrAck", {31'b0, a}, 32'd0);
        checkOutput("badAddrBusy", {31'b0, busy}, 32'd0);
        writeByte(8'h00, a);
        checkOutput("badAddrByteAck", {31'b0, a}, 32'd0);
        checkOutput("badAddrBusy2", {31'b0, busy}, 32'd0);
        busStop();

        $display("[TB] Partial Thyst write and Temp data write");
        doWrite(8'h02, 1, 8'h20, 8'h00, 8'h00);
        doRead(2, 1'b0, 16'h0000);
        doWrite(8'h00, 1, 8'h12, 8'h00, 8'h00);

        $display("[TB] Os hysteresis sweep and polarity");
        applyStimulus(16'h5000);
        applyStimulus(16'h4C00);
        applyStimulus(16'h4A80);
        doWrite(8'h01, 1, 8'h04, 8'h00, 8'h00);
        applyStimulus(16'h5080);
        doWrite(8'h01, 1, 8'h00, 8'h00, 8'h00);

        $display("[TB] Temp snapshot held across the read");
        doWrite(8'h00, 0, 8'h00, 8'h00, 8'h00);
        temp = 16'h2A80;
        doRead(3, 1'b1, 16'hE700);

        $display("[TB] Randomized transactions");
        for (int it = 0; it < 30; it++) begin
            t9 = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(9'h8C, 9'hAA));
            applyStimulus({t9, 7'($urandom)});
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                doWrite({6'($urandom), 2'($urandom)}, $urandom_range(0, 3),
                        8'($urandom), 8'($urandom), 8'($urandom));
            end else if (sel == 1) begin
                doRead($urandom_range(1, 4), 1'b0, 16'h0000);
            end else begin
                doWrite({6'($urandom), 2'($urandom)}, 0, 8'h00, 8'h00, 8'h00);
                doRead($urandom_range(1, 4), 1'b0, 16'h0000);
            end
        end

        $display("[TB] Reset during a read bit");
        doWrite(8'h00, 0, 8'h00, 8'h00, 8'h00);
        temp = 16'h0000;
        busStart();
        writeByte(8'h91, a);
        checkOutput("rstRdAddrAck", {31'b0, a}, 32'd1);
        for (int i = 0; i < 3; i++) readBit(bit_);
        checkOutput("oeBeforeRst", {31'b0, sdaOe}, 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("oeAtRst", {31'b0, sdaOe}, 32'd0);
        checkOutput("busyAtRst", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("osAtRst", {31'b0, os}, 32'd0);
        modelReset();
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        modelOsStep();
        temp = 16'h1980;
        doRead(2, 1'b0, 16'h0000);
        doWrite(8'h03, 0, 8'h00, 8'h00, 8'h00);
        doRead(2, 1'b0, 16'h0000);
        doWrite(8'h02, 0, 8'h00, 8'h00, 8'h00);
        doRead(2, 1'b0, 16'h0000);
        doWrite(8'h01, 0, 8'h00, 8'h00, 8'h00);
        doRead(2, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
